// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU sequencer block:
//   - controller state encoding (IDLE, DECODE, EXEC, WB)
//   - instruction field layout (packed struct, MSB first)
//   - datapath / register-file widths
//   - flag bit order {N, Zero, C, V, D} and a helper that packs it
// -----------------------------------------------------------------------------
package alu_seq_pkg;

    localparam int INSTR_W  = 24;
    localparam int DATA_W   = 8;
    localparam int FS_W     = 4;
    localparam int SH_W     = 3;
    localparam int REG_AW   = 3;
    localparam int NUM_REGS = 8;
    localparam int FLAGS_W  = 5;

    // Bit positions inside the flag vector; N is the MSB, D the LSB.
    localparam int FLAG_N = 4;
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_D = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_t;

    // Field order matches the instruction word:
    // [23:20] FS, [19:17] SH, [16:14] RD, [13:11] RA, [10:8] RB, [7:0] K
    typedef struct packed {
        logic [FS_W-1:0]   fs;
        logic [SH_W-1:0]   sh;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] ra;
        logic [REG_AW-1:0] rb;
        logic [DATA_W-1:0] k;
    } instr_t;

    // Assemble the five ALU flags into the architectural flag order.
    function automatic logic [FLAGS_W-1:0] pack_flags(
        input logic n,
        input logic z,
        input logic c,
        input logic v,
        input logic d
    );
        logic [FLAGS_W-1:0] f;
        f         = {FLAGS_W{1'b0}};
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        f[FLAG_D] = d;
        return f;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_sequencer_if
// Groups the instruction handshake and the ALU drive/result bus.
//   slave  : the sequencer (accepts instructions, drives the ALU inputs,
//            consumes the ALU result and flags)
//   master : the instruction source together with the ALU
// Signals:
//   instr_valid / instr_ready / instr / in_data : instruction handshake
//   fs, sh, a, b, alu_in, ink                   : registered ALU drives
//   f, n, zero, c, v, d                         : ALU result and flags
// -----------------------------------------------------------------------------
interface alu_sequencer_if;
    import alu_seq_pkg::*;

    logic                  instr_valid;
    logic                  instr_ready;
    logic [INSTR_W-1:0]    instr;
    logic [DATA_W-1:0]     in_data;

    logic [FS_W-1:0]       fs;
    logic [SH_W-1:0]       sh;
    logic [DATA_W-1:0]     a;
    logic [DATA_W-1:0]     b;
    logic [DATA_W-1:0]     alu_in;
    logic [DATA_W-1:0]     ink;

    logic [DATA_W-1:0]     f;
    logic                  n;
    logic                  zero;
    logic                  c;
    logic                  v;
    logic                  d;

    modport slave (
        input  instr_valid, instr, in_data,
        input  f, n, zero, c, v, d,
        output instr_ready,
        output fs, sh, a, b, alu_in, ink
    );

    modport master (
        output instr_valid, instr, in_data,
        output f, n, zero, c, v, d,
        input  instr_ready,
        input  fs, sh, a, b, alu_in, ink
    );

endinterface

// File: rtl/alu_regfile.sv
// -----------------------------------------------------------------------------
// alu_regfile
// 8 x 8-bit register file for the ALU sequencer.
// Ports:
//   i_clk, i_rst               : clock, synchronous active-high reset (clears all)
//   i_we, i_waddr, i_wdata     : synchronous write port
//   i_raddr_a / o_rdata_a      : combinational read port A
//   i_raddr_b / o_rdata_b      : combinational read port B
//   i_dbg_addr / o_dbg_data    : combinational debug read port
// Reset has priority over the write, so a write requested in the reset
// cycle is dropped.
// -----------------------------------------------------------------------------
module alu_regfile
    import alu_seq_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [REG_AW-1:0] i_raddr_a,
    output logic [DATA_W-1:0] o_rdata_a,
    input  logic [REG_AW-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_b,
    input  logic [REG_AW-1:0] i_dbg_addr,
    output logic [DATA_W-1:0] o_dbg_data
);

    logic [DATA_W-1:0] r_mem [NUM_REGS];

    // Storage: clear on reset, otherwise single write port.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= {DATA_W{1'b0}};
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a  = r_mem[i_raddr_a];
    assign o_rdata_b  = r_mem[i_raddr_b];
    assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
// Multi-cycle controller for the 8-bit combinational ALU. Accepts one
// instruction at a time, reads two operands from the register file, drives
// them with the decoded FS/SH/K fields and the external operand onto the ALU,
// waits EXEC_WAIT cycles, then writes F back and latches the flags.
// Sequence: IDLE -> DECODE -> EXEC (EXEC_WAIT cycles) -> WB -> IDLE.
// Parameters:
//   EXEC_WAIT : cycles the ALU inputs are held before F is sampled (>= 1)
//   CNT_W     : width of the retired-instruction counter (wraps silently)
// Ports:
//   i_clk, i_rst  : clock, synchronous active-high reset (aborts any state)
//   bus           : instruction handshake + ALU bus (slave side)
//   o_result      : F as last written back
//   o_flags       : {N,Zero,C,V,D} latched at write-back
//   o_done        : high during the write-back cycle
//   o_retired     : completed-instruction count
//   i_dbg_addr / o_dbg_data : combinational register-file peek
// -----------------------------------------------------------------------------
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int EXEC_WAIT = 1,
    parameter int CNT_W     = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    alu_sequencer_if.slave     bus,
    output logic [DATA_W-1:0]  o_result,
    output logic [FLAGS_W-1:0] o_flags,
    output logic               o_done,
    output logic [CNT_W-1:0]   o_retired,
    input  logic [REG_AW-1:0]  i_dbg_addr,
    output logic [DATA_W-1:0]  o_dbg_data
);

    // The counter only needs to hold EXEC_WAIT-1.
    localparam int WAIT_W = (EXEC_WAIT > 1) ? $clog2(EXEC_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(EXEC_WAIT - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [WAIT_W-1:0]  r_wait_cnt;
    instr_t             r_instr;
    logic [DATA_W-1:0]  r_in_data;

    logic [FS_W-1:0]    r_fs;
    logic [SH_W-1:0]    r_sh;
    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  r_b;
    logic [DATA_W-1:0]  r_alu_in;
    logic [DATA_W-1:0]  r_ink;

    logic [DATA_W-1:0]  r_result;
    logic [FLAGS_W-1:0] r_flags;
    logic [CNT_W-1:0]   r_retired;

    logic               w_accept;
    logic               w_we;
    logic [DATA_W-1:0]  w_rdata_a;
    logic [DATA_W-1:0]  w_rdata_b;

    // Ready and done are qualified with reset so neither is seen while
    // reset is asserted, including a reset landing in the WB cycle.
    assign bus.instr_ready = (r_state == ST_IDLE) && !i_rst;
    assign o_done          = (r_state == ST_WB) && !i_rst;
    assign w_accept        = bus.instr_ready && bus.instr_valid;
    assign w_we            = (r_state == ST_WB);

    alu_regfile u_regfile (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_we       (w_we),
        .i_waddr    (r_instr.rd),
        .i_wdata    (bus.f),
        .i_raddr_a  (r_instr.ra),
        .o_rdata_a  (w_rdata_a),
        .i_raddr_b  (r_instr.rb),
        .o_rdata_b  (w_rdata_b),
        .i_dbg_addr (i_dbg_addr),
        .o_dbg_data (o_dbg_data)
    );

    // Controller state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.instr_valid) begin
                    w_next_state = ST_DECODE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_DECODE: begin
                w_next_state = ST_EXEC;
            end
            ST_EXEC: begin
                if (r_wait_cnt == {WAIT_W{1'b0}}) begin
                    w_next_state = ST_WB;
                end else begin
                    w_next_state = ST_EXEC;
                end
            end
            ST_WB: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // EXEC down-counter: loaded in DECODE so EXEC lasts exactly EXEC_WAIT cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wait_cnt <= {WAIT_W{1'b0}};
        end else if (r_state == ST_DECODE) begin
            r_wait_cnt <= WAIT_LOAD;
        end else if ((r_state == ST_EXEC) && (r_wait_cnt != {WAIT_W{1'b0}})) begin
            r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
        end
    end

    // Instruction and external-operand latches; later bus changes are ignored.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_instr   <= instr_t'({INSTR_W{1'b0}});
            r_in_data <= {DATA_W{1'b0}};
        end else if (w_accept) begin
            r_instr   <= instr_t'(bus.instr);
            r_in_data <= bus.in_data;
        end
    end

    // ALU drive registers: loaded at the end of DECODE, held otherwise so
    // they stay stable through EXEC and WB.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fs     <= {FS_W{1'b0}};
            r_sh     <= {SH_W{1'b0}};
            r_a      <= {DATA_W{1'b0}};
            r_b      <= {DATA_W{1'b0}};
            r_alu_in <= {DATA_W{1'b0}};
            r_ink    <= {DATA_W{1'b0}};
        end else if (r_state == ST_DECODE) begin
            r_fs     <= r_instr.fs;
            r_sh     <= r_instr.sh;
            r_a      <= w_rdata_a;
            r_b      <= w_rdata_b;
            r_alu_in <= r_in_data;
            r_ink    <= r_instr.k;
        end
    end

    // Write-back side: result, flags and retired count update at the end of WB.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_result  <= {DATA_W{1'b0}};
            r_flags   <= {FLAGS_W{1'b0}};
            r_retired <= {CNT_W{1'b0}};
        end else if (r_state == ST_WB) begin
            r_result  <= bus.f;
            r_flags   <= pack_flags(bus.n, bus.zero, bus.c, bus.v, bus.d);
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign bus.fs     = r_fs;
    assign bus.sh     = r_sh;
    assign bus.a      = r_a;
    assign bus.b      = r_b;
    assign bus.alu_in = r_alu_in;
    assign bus.ink    = r_ink;

    assign o_result   = r_result;
    assign o_flags    = r_flags;
    assign o_retired  = r_retired;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller that sequences the 8-bit `alu` datapath. It accepts one 24-bit instruction at a time over a valid/ready handshake and owns an 8×8 register file. For each instruction it reads two operands, drives them and the decoded `FS`/`SH`/`INK` fields onto the ALU, waits for the result to settle, then writes `F` back and latches the flags. It sits between the instruction source (sequencer ROM or testbench) and the combinational `alu`.

## Interface
- `EXEC_WAIT`, default 1: cycles the ALU inputs are held stable before `F` is sampled (≥1).
- `CNT_W`, default 16: width of the retired-instruction counter.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instr_valid` in 1: instruction present.
- `instr` in 24: instruction, fields as follows.
  - [23:20] FS
  - [19:17] SH
  - [16:14] RD
  - [13:11] RA
  - [10:8] RB
  - [7:0] K
- `instr_ready` out 1: high only in IDLE.
- `in_data` in 8: external operand, sampled at accept.
- `FS` out 4, `SH` out 3, `A` out 8, `B` out 8, `IN` out 8, `INK` out 8: registered drives to the ALU.
- `F` in 8, `N` `Zero` `C` `V` `D` in 1 each: ALU result and flags.
- `result` out 8: `F` as written back, held until the next WB.
- `flags` out 5: {N,Zero,C,V,D}, latched at WB.
- `done` out 1: one-cycle pulse during the WB cycle.
- `retired` out CNT_W: count of completed instructions.
- `dbg_addr` in 3, `dbg_data` out 8: combinational register-file read.

## Operation
- States: IDLE → DECODE → EXEC → WB → IDLE.
- IDLE: `instr_ready`=1. When `instr_valid`, latch `instr` and `in_data` and go to DECODE.
- DECODE, 1 cycle: at the end of the cycle, register the ALU drives.
  - `A`←R[RA], `B`←R[RB]
  - `FS`, `SH` from the instruction fields
  - `INK`←K, `IN`←latched `in_data`
- EXEC: stay for EXEC_WAIT cycles using a down-counter. Drives are held constant.
- WB, 1 cycle:
  - `done`=1.
  - At the end of the cycle: R[RD]←F, `result`←F, `flags`←{N,Zero,C,V,D}, `retired`+1.
- The controller does not interpret FS/SH. The ALU drives hold their last values outside DECODE, so they are stable through WB.
- RA=RB and RD=RA/RB are legal. Operands are read in DECODE, before the write.
- Read-after-write to the next instruction needs no bypass, because the write completes before the next DECODE.
- `retired` wraps from 2^CNT_W−1 to 0 silently.
- `instr_valid` outside IDLE is ignored, and `instr` changes are ignored after acceptance.
- `dbg_data` reflects a WB write from the cycle after WB.

## Timing
- An instruction accepted at edge k has DECODE in cycle k+1, EXEC in cycles k+2 … k+1+EXEC_WAIT, and WB in cycle k+2+EXEC_WAIT.
- The next accept is possible at the earliest edge ending the cycle after WB.
- Back-to-back throughput is 1 instruction per 3+EXEC_WAIT cycles (4 at the default).
- Reset values:
  - state IDLE
  - R0–R7 = 0
  - `FS` `SH` `A` `B` `IN` `INK` `result` `flags` `retired` = 0
  - `done`=0
  - `instr_ready`=0 while `rst` is high, 1 in the first cycle after release
- Reset mid-operation, in any state: abort, no register write, no `done`, no counter increment.
- Reset in the WB cycle: the write is suppressed (reset wins).

## Structure
- Shared package/include `alu_seq_pkg`:
  - state encoding (IDLE, DECODE, EXEC, WB)
  - instruction field bit positions
  - flag bit order {N,Zero,C,V,D}
- Sub-module `alu_regfile`: 8×8, two combinational read ports plus a debug read port, one synchronous write port, synchronous reset to zero.
- Top level holds the FSM, the EXEC counter, the instruction/`in_data` latches, the ALU drive registers, the flag register and the counter.

## Test plan
Bench uses an ALU stub: F = A ^ B ^ INK, flags = {FS[0],F==0,SH[0],FS[1],FS[2]}.

1. Reset, then `dbg_addr` 0–7 → all 0. After release, `instr_ready`=1, `retired`=0, `done`=0.
2. Instruction RD=1, K=8'h5A, RA=RB=0, FS=4'h3, SH=3'd1:
   - `done` in cycle k+3
   - R1=8'h5A
   - `flags`=5'b10110
   - `retired`=1
3. Chained dependency: R1=5A, then RD=2 RA=1 RB=1 K=0F → R2=0F. `done` pulses exactly 4 cycles apart with `instr_valid` held high.
4. `instr_valid` pulsed in DECODE/EXEC/WB → ignored. Only one `done` per accepted instruction, and `instr_ready`=0 in those states.
5. `rst` asserted in EXEC of a write to R3=8'hFF → R3 stays 0, no `done`, `retired` unchanged, state IDLE next cycle.
6. EXEC_WAIT=3 build: `done` at k+5. With CNT_W=4, 16 instructions → `retired` wraps to 0.
